// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and segment decode table for seg7_to_hex.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned HEX_W = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_0 = 7'h7E;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h33;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h5F;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h70;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h7B;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h1F;
  localparam logic [SEG_W-1:0] SEG_C = 7'h4E;
  localparam logic [SEG_W-1:0] SEG_D = 7'h3D;
  localparam logic [SEG_W-1:0] SEG_E = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_F = 7'h47;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_STABLE = 2'd1,
    ST_EMIT        = 2'd2,
    ST_HOLD        = 2'd3
  } state_e;

  typedef struct packed {
    logic             hit;
    logic [HEX_W-1:0] hex;
  } decode_t;

  function automatic decode_t seg_decode(input logic [SEG_W-1:0] pat);
    decode_t d;
    d.hit = 1'b1;
    d.hex = 4'h0;
    case (pat)
      SEG_0:   d.hex = 4'h0;
      SEG_1:   d.hex = 4'h1;
      SEG_2:   d.hex = 4'h2;
      SEG_3:   d.hex = 4'h3;
      SEG_4:   d.hex = 4'h4;
      SEG_5:   d.hex = 4'h5;
      SEG_6:   d.hex = 4'h6;
      SEG_7:   d.hex = 4'h7;
      SEG_8:   d.hex = 4'h8;
      SEG_9:   d.hex = 4'h9;
      SEG_A:   d.hex = 4'hA;
      SEG_B:   d.hex = 4'hB;
      SEG_C:   d.hex = 4'hC;
      SEG_D:   d.hex = 4'hD;
      SEG_E:   d.hex = 4'hE;
      SEG_F:   d.hex = 4'hF;
      default: d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Synchronizes the segment bus and flags when a pattern has held for STABLE_CYCLES.
// SEG_ACTIVE_LOW_EN: invert the synchronized bus (common-anode display).
module seg_stable_filter
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] seg_in,
  output logic [SEG_W-1:0] stable_pat,
  output logic             change_c,
  output logic             stable_stb_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SEG_W-1:0] sync1_q, sync2_q;
  logic [SEG_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEG_W-1:0] sample_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= SEG_BLANK;
      sync2_q <= SEG_BLANK;
      cand_q  <= SEG_BLANK;
      cnt_q   <= '0;
    end else begin
      sync1_q <= seg_in;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Candidate reload on any change; counter saturates, strobe fires once on arrival.
  always_comb begin
`ifdef SEG_ACTIVE_LOW_EN
    sample_c = ~sync2_q;
`else
    sample_c = sync2_q;
`endif
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    change_c     = 1'b0;
    stable_stb_c = 1'b0;
    if (sample_c != cand_q) begin
      change_c     = 1'b1;
      cand_d       = sample_c;
      cnt_d        = '0;
      stable_stb_c = (CNT_MAX == '0);
    end else if (cnt_q < CNT_MAX) begin
      cnt_d        = cnt_q + CNT_W'(1);
      stable_stb_c = (cnt_d == CNT_MAX);
    end
  end

  assign stable_pat = cand_q;

endmodule

// File: rtl/seg7_to_hex.sv
// Decodes a debounced seven-segment bus into a hex digit with valid/error/blank flags.
// SEG_ACTIVE_LOW_EN: treat seg_in as an active-low (common-anode) bus.
module seg7_to_hex
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] seg_in,
  output logic [HEX_W-1:0] hex_out,
  output logic             hex_valid,
  output logic             seg_err,
  output logic             blank
);

  logic [SEG_W-1:0] stable_pat;
  logic             change_c;
  logic             stable_stb_c;

  state_e           state_q, state_d;
  logic [SEG_W-1:0] ref_q, ref_d;
  logic [HEX_W-1:0] hex_q, hex_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             blank_q, blank_d;
  decode_t          dec_c;

  seg_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .stable_pat  (stable_pat),
    .change_c    (change_c),
    .stable_stb_c(stable_stb_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ref_q   <= SEG_BLANK;
      hex_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      hex_q   <= hex_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      blank_q <= blank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    hex_d   = hex_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    blank_d = blank_q;
    dec_c   = seg_decode(stable_pat);
    case (state_q)
      // Candidate may already differ from the reference if it moved during EMIT.
      ST_IDLE, ST_HOLD: begin
        if (stable_stb_c)                           state_d = ST_EMIT;
        else if (change_c || (stable_pat != ref_q)) state_d = ST_WAIT_STABLE;
      end
      ST_WAIT_STABLE: begin
        if (stable_stb_c) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        ref_d = stable_pat;
        if (stable_pat == SEG_BLANK) begin
          blank_d = 1'b1;
        end else begin
          blank_d = 1'b0;
          if (dec_c.hit) begin
            hex_d   = dec_c.hex;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        state_d = stable_stb_c ? ST_EMIT : ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign hex_out   = hex_q;
  assign hex_valid = valid_q;
  assign seg_err   = err_q;
  assign blank     = blank_q;

endmodule

// File: tb/tb_seg7_to_hex.sv
// Directed self-checking bench for seg7_to_hex (STABLE_CYCLES=4).
module tb_seg7_to_hex;

  logic       clk;
  logic       rst;
  logic [6:0] seg_in;
  logic [3:0] hex_out;
  logic       hex_valid;
  logic       seg_err;
  logic       blank;

  int checks = 0;
  int errors = 0;
  int n_valid, n_err, n_both, first_valid, tick_no;

  seg7_to_hex #(.STABLE_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .seg_in   (seg_in),
    .hex_out  (hex_out),
    .hex_valid(hex_valid),
    .seg_err  (seg_err),
    .blank    (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Map a logical (active-high) pattern onto the physical bus.
  function automatic logic [6:0] phys(input logic [6:0] p);
`ifdef SEG_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_err = 0;
    first_valid = -1;
    tick_no = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tick_no++;
      if (hex_valid) begin
        n_valid++;
        if (first_valid < 0) first_valid = tick_no;
      end
      if (seg_err) n_err++;
      if (hex_valid && seg_err) n_both++;
    end
  endtask

  initial begin
    n_both = 0;
    rst = 1'b1;
    seg_in = phys(7'h00);
    clear_counts();
    run(3);
    check("reset_hex", int'(hex_out), 0);
    check("reset_valid", int'(hex_valid), 0);
    check("reset_err", int'(seg_err), 0);
    check("reset_blank", int'(blank), 1);
    rst = 1'b0;
    run(4);

    // Single digit 2, latency 2 + 4 + 1
    seg_in = phys(7'h6D);
    clear_counts();
    run(10);
    check("d2_count", n_valid, 1);
    check("d2_latency", first_valid, 7);
    check("d2_hex", int'(hex_out), 2);
    check("d2_blank", int'(blank), 0);

    // Toggle 1/3 every 2 cycles, then settle on 3
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      seg_in = phys(7'h30);
      run(2);
      seg_in = phys(7'h79);
      run(2);
    end
    check("toggle_nopulse", n_valid + n_err, 0);
    clear_counts();
    run(12);
    check("settle_count", n_valid, 1);
    check("settle_hex", int'(hex_out), 3);

    // Unknown pattern -> error pulse, digit kept
    seg_in = phys(7'h01);
    clear_counts();
    run(12);
    check("bad_err", n_err, 1);
    check("bad_valid", n_valid, 0);
    check("bad_hex", int'(hex_out), 3);

    // 8, blank, 8 again
    seg_in = phys(7'h7F);
    clear_counts();
    run(12);
    check("e8a_count", n_valid, 1);
    check("e8a_hex", int'(hex_out), 8);
    check("e8a_blank", int'(blank), 0);
    seg_in = phys(7'h00);
    clear_counts();
    run(12);
    check("blank_pulses", n_valid + n_err, 0);
    check("blank_level", int'(blank), 1);
    check("blank_hex", int'(hex_out), 8);
    seg_in = phys(7'h7F);
    clear_counts();
    run(12);
    check("e8b_count", n_valid, 1);
    check("e8b_hex", int'(hex_out), 8);
    check("e8b_blank", int'(blank), 0);

    // Reset 2 cycles into WAIT_STABLE on C
    seg_in = phys(7'h4E);
    clear_counts();
    run(4);
    rst = 1'b1;
    #1;
    check("rst_hex", int'(hex_out), 0);
    check("rst_blank", int'(blank), 1);
    run(2);
    check("rst_valid", int'(hex_valid), 0);
    check("rst_err", int'(seg_err), 0);
    rst = 1'b0;
    check("rst_nopulse", n_valid + n_err, 0);
    clear_counts();
    run(12);
    check("c_count", n_valid, 1);
    check("c_latency", first_valid, 7);
    check("c_hex", int'(hex_out), 12);

`ifdef SEG_ACTIVE_LOW_EN
    // Raw physical values on a common-anode bus
    seg_in = 7'h01;
    clear_counts();
    run(12);
    check("al_count", n_valid, 1);
    check("al_hex", int'(hex_out), 0);
    seg_in = 7'h7F;
    clear_counts();
    run(12);
    check("al_blank", int'(blank), 1);
`endif

    check("never_both", n_both, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_to_hex.md
SEG7_TO_HEX -- requirements
Module: seg7_to_hex

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive cycles a sampled pattern must stay unchanged before it is decoded (legal range 1..255).
REQ-002 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: SHALL be an asynchronous, active-high reset.
REQ-004 Port seg_in, input, 7: asynchronous segment bus from external display, bit6=a ... bit0=g, active-high (common cathode).
REQ-005 Port hex_out, output, 4: last successfully decoded digit 0x0..0xF.
REQ-006 Port hex_valid, output, 1: single-cycle pulse when hex_out is updated.
REQ-007 Port seg_err, output, 1: single-cycle pulse when a stable pattern matches no table entry.
REQ-008 Port blank, output, 1: level, high while the stable pattern is 0x00 (all segments off).

Function
REQ-009 seg_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 Decode table (seg -> hex) SHALL be exactly: 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 77->A, 1F->B, 4E->C, 3D->D, 4F->E, 47->F.
REQ-011 FSM SHALL have states IDLE, WAIT_STABLE, EMIT, HOLD.
REQ-012 IDLE: on the first synchronized sample differing from the held reference pattern, SHALL load it as the candidate, clear the stability counter, go to WAIT_STABLE.
REQ-013 WAIT_STABLE: the counter SHALL increment each cycle the sample equals the candidate; any differing sample SHALL reload the candidate and clear the counter (stay in WAIT_STABLE).
REQ-014 When the counter reaches STABLE_CYCLES-1 with the sample still equal, the FSM SHALL go to EMIT.
REQ-015 EMIT (one cycle): candidate becomes the reference; table hit -> hex_out updated and hex_valid=1; 0x00 -> blank=1, no pulse; other miss -> seg_err=1, hex_out unchanged; then go to HOLD.
REQ-016 HOLD SHALL be left for WAIT_STABLE (as in REQ-012) only when the sample differs from the reference; the same pattern SHALL never be re-emitted.
REQ-017 Latency from a seg_in change to hex_valid SHALL be 2 (sync) + STABLE_CYCLES + 1 cycles.
REQ-018 hex_valid and seg_err SHALL never be high in the same cycle; blank SHALL clear in the EMIT of any non-zero pattern.
REQ-019 The counter SHALL be 8 bits and SHALL NOT wrap; it saturates at STABLE_CYCLES-1.

Reset
REQ-020 On rst: hex_out=0x0, hex_valid=0, seg_err=0, blank=1, reference=0x00, synchronizer flops=0x00, counter=0, state=IDLE.
REQ-021 rst asserted mid-WAIT_STABLE or in EMIT SHALL discard the candidate with no pulse emitted.

Configuration
REQ-022 Macro SEG_ACTIVE_LOW_EN defined: seg_in SHALL be inverted after the synchronizer (common-anode bus) and all table, blank and reset-reference rules apply to the inverted value; undefined: seg_in used as-is.

Structure
REQ-023 Package seg7_pkg SHALL hold the 16 pattern constants, the SEG_BLANK constant (0x00) and the FSM state enum type.
REQ-024 Synchronizer plus stability counter SHALL be one sub-module, seg_stable_filter, outputting a stable pattern and a one-cycle stable strobe; seg7_to_hex holds FSM and table.

Verification
REQ-025 After reset, seg_in=0x6D held 10 cycles (STABLE_CYCLES=4) -> one hex_valid pulse exactly 7 cycles after the change, hex_out=0x2.
REQ-026 seg_in toggles 0x30/0x79 every 2 cycles for 20 cycles, then settles on 0x79 -> no pulse during toggling, one hex_valid with hex_out=0x3 after settling.
REQ-027 seg_in=0x01 held -> one seg_err pulse, hex_out keeps its previous value, no hex_valid.
REQ-028 0x7F held, then 0x00 held, then 0x7F held -> hex_valid (0x8), blank=1 with no pulse, hex_valid (0x8) again.
REQ-029 rst pulsed 2 cycles into WAIT_STABLE on 0x4E -> no pulse; all outputs at REQ-020 values; re-stabilised 0x4E then yields hex_out=0xC.
REQ-030 With SEG_ACTIVE_LOW_EN, seg_in=0x01 (inverted 0x7E) held -> hex_valid, hex_out=0x0; seg_in=0x7F -> blank=1.
